// File: rtl/cond_exec_ctrl.sv
// cond_exec_ctrl -- EX-stage conditional-execution controller.
// Holds the architectural NZCV register, evaluates the EX instruction's
// condition field against it, decides execute/squash, commits ALU flags
// for S-bit ops and sequences multi-cycle flag producers (e.g. MUL) by
// stalling EX for MC_LATENCY cycles.
// Optional feature: define COND_TRACE_EN to add exec/squash trace counters.
//
// Stall handshake: while stall=1 the upstream pipeline must hold IF/ID/EX,
// so every ex_* input stays stable; the op in EX completes on the cycle
// mc_done=1 (stall=0), and the next instruction is presented the cycle after.
module cond_exec_ctrl #(
  parameter int MC_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             ex_valid,
  input  logic [3:0]       ex_cond,
  input  logic             ex_s_bit,
  input  logic             ex_multicycle,
  input  logic [3:0]       alu_flags,
  output logic [3:0]       status_q,
  output logic             cond_met,
  output logic             ex_exec,
  output logic             stall,
  output logic             mc_done
`ifdef COND_TRACE_EN
  ,
  output logic [CNT_W-1:0] exec_count,
  output logic [CNT_W-1:0] squash_count
`endif
);

  // Counter holds at most MC_LATENCY-2, which always fits in clog2(MC_LATENCY) bits.
  localparam int CW = (MC_LATENCY > 2) ? $clog2(MC_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MC_LATENCY - 2);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] MC_RUN = 1'b1;

  logic [0:0]    state_q;
  logic [CW-1:0] cnt_q;
  logic          s_lat_q;

  logic flag_n, flag_z, flag_c, flag_v;
  logic in_idle;

  assign flag_n  = status_q[3];
  assign flag_z  = status_q[2];
  assign flag_c  = status_q[1];
  assign flag_v  = status_q[0];
  assign in_idle = (state_q == IDLE);

  // Condition-field evaluation against the architectural flags.
  always_comb begin
    cond_met = 1'b0;
    case (ex_cond)
      4'b0000: cond_met = flag_z;
      4'b0001: cond_met = ~flag_z;
      4'b0010: cond_met = flag_c;
      4'b0011: cond_met = ~flag_c;
      4'b0100: cond_met = flag_n;
      4'b0101: cond_met = ~flag_n;
      4'b0110: cond_met = flag_v;
      4'b0111: cond_met = ~flag_v;
      4'b1000: cond_met = flag_c & ~flag_z;
      4'b1001: cond_met = ~flag_c | flag_z;
      4'b1010: cond_met = (flag_n == flag_v);
      4'b1011: cond_met = (flag_n != flag_v);
      4'b1100: cond_met = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_met = flag_z | (flag_n != flag_v);
      4'b1110: cond_met = 1'b1;
      default: cond_met = 1'b0;
    endcase
  end

  // Execute/stall/done decode; stall depends only on state, not on freeze, in MC_RUN.
  always_comb begin
    ex_exec = ex_valid & cond_met & in_idle & ~freeze;
    stall   = 1'b0;
    mc_done = 1'b0;
    if (in_idle) begin
      stall = ex_exec & ex_multicycle;
    end else begin
      stall   = (cnt_q != '0);
      mc_done = (cnt_q == '0) & ~freeze;
    end
  end

  // FSM, multi-cycle counter, latched S bit and NZCV register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      s_lat_q  <= 1'b0;
      status_q <= 4'b0000;
    end else if (!freeze) begin
      case (state_q)
        IDLE: begin
          if (ex_exec) begin
            if (ex_multicycle) begin
              state_q <= MC_RUN;
              cnt_q   <= CNT_LOAD;
              s_lat_q <= ex_s_bit;
            end else if (ex_s_bit) begin
              status_q <= alu_flags;
            end
          end
        end
        default: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
            if (s_lat_q) status_q <= alu_flags;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
      endcase
    end
  end

`ifdef COND_TRACE_EN
  // Trace counters: one count per executed instruction, one per squashed IDLE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exec_count   <= '0;
      squash_count <= '0;
    end else begin
      if (ex_exec) exec_count <= exec_count + 1'b1;
      if (in_idle && !freeze && ex_valid && !cond_met) squash_count <= squash_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cond_exec_ctrl.sv
// tb_cond_exec_ctrl -- directed plus randomized bench for cond_exec_ctrl.
// Reference model tracks time as a count of non-frozen cycles: a multi-cycle
// op accepted at tick T finishes at tick T+MC_LATENCY-1.
module tb_cond_exec_ctrl;
  localparam int MC_LATENCY = 4;
  localparam int CNT_W      = 4;

  logic clk = 1'b0;
  logic rst, freeze, ex_valid, ex_s_bit, ex_multicycle;
  logic [3:0] ex_cond, alu_flags, status_q;
  logic cond_met, ex_exec, stall, mc_done;
`ifdef COND_TRACE_EN
  logic [CNT_W-1:0] exec_count, squash_count;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [3:0]       m_status;
  bit               m_busy;
  bit               m_s;
  int               m_t;
  int               m_done_t;
  logic [CNT_W-1:0] m_exec_cnt;
  logic [CNT_W-1:0] m_squash_cnt;

  cond_exec_ctrl #(.MC_LATENCY(MC_LATENCY), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .freeze        (freeze),
    .ex_valid      (ex_valid),
    .ex_cond       (ex_cond),
    .ex_s_bit      (ex_s_bit),
    .ex_multicycle (ex_multicycle),
    .alu_flags     (alu_flags),
    .status_q      (status_q),
    .cond_met      (cond_met),
    .ex_exec       (ex_exec),
    .stall         (stall),
    .mc_done       (mc_done)
`ifdef COND_TRACE_EN
    ,
    .exec_count    (exec_count),
    .squash_count  (squash_count)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  // Architectural condition rules written in terms of named flags.
  function automatic bit cond_fn(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cf && !z;
      4'd9:  return !cf || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit v, input logic [3:0] c, input bit s, input bit mc, input logic [3:0] f);
    ex_valid = v; ex_cond = c; ex_s_bit = s; ex_multicycle = mc; alu_flags = f;
  endtask

  task automatic model_reset();
    m_status = 4'b0000; m_busy = 0; m_s = 0; m_t = 0; m_done_t = 0;
    m_exec_cnt = '0; m_squash_cnt = '0;
  endtask

  // One clock: compare all outputs at negedge against the model, advance model at posedge.
  task automatic tick(input string tag);
    bit e_cond, e_exec, e_stall, e_done, finishing;
    @(negedge clk);
    e_cond    = cond_fn(ex_cond, m_status);
    e_exec    = ex_valid && e_cond && !m_busy && !freeze;
    finishing = m_busy && (m_t == m_done_t);
    e_stall   = m_busy ? (m_t < m_done_t) : (e_exec && ex_multicycle);
    e_done    = finishing && !freeze;
    chk({tag, ".cond_met"}, 16'(cond_met), 16'(e_cond));
    chk({tag, ".ex_exec"},  16'(ex_exec),  16'(e_exec));
    chk({tag, ".stall"},    16'(stall),    16'(e_stall));
    chk({tag, ".mc_done"},  16'(mc_done),  16'(e_done));
    chk({tag, ".status"},   16'(status_q), 16'(m_status));
`ifdef COND_TRACE_EN
    chk({tag, ".exec_cnt"},   16'(exec_count),   16'(m_exec_cnt));
    chk({tag, ".squash_cnt"}, 16'(squash_count), 16'(m_squash_cnt));
`endif
    @(posedge clk);
    if (!freeze) begin
      if (finishing) begin
        m_busy = 0;
        if (m_s) m_status = alu_flags;
      end else if (e_exec) begin
        if (ex_multicycle) begin
          m_busy = 1; m_s = ex_s_bit; m_done_t = m_t + MC_LATENCY - 1;
        end else if (ex_s_bit) begin
          m_status = alu_flags;
        end
      end
      if (e_exec) m_exec_cnt++;
      if (!m_busy && !finishing && ex_valid && !e_cond) m_squash_cnt++;
      m_t++;
    end
    #1;
  endtask

  // Asynchronous reset pulse between clock edges; checks the immediate effect.
  task automatic do_reset(input string tag);
    set_in(0, 4'd0, 0, 0, 4'd0);
    freeze = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    chk({tag, ".rst_status"}, 16'(status_q), 16'd0);
    chk({tag, ".rst_stall"},  16'(stall),    16'd0);
    chk({tag, ".rst_done"},   16'(mc_done),  16'd0);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    // Reset
    rst = 1'b1; freeze = 1'b0;
    set_in(0, 4'd0, 0, 0, 4'd0);
    model_reset();
    #12;
    rst = 1'b0;
    chk("reset.status", 16'(status_q), 16'd0);
    chk("reset.stall",  16'(stall),    16'd0);
    chk("reset.done",   16'(mc_done),  16'd0);

    // 1: EQ fails on zero flags, AL executes
    set_in(1, 4'b0000, 0, 0, 4'd0); #1;
    chk("t1.eq_met",  16'(cond_met), 16'd0);
    chk("t1.eq_exec", 16'(ex_exec),  16'd0);
    tick("t1.eq");
    set_in(1, 4'b1110, 0, 0, 4'd0); #1;
    chk("t1.al_exec", 16'(ex_exec), 16'd1);
    tick("t1.al");
    chk("t1.status", 16'(status_q), 16'd0);

    // 2: S-bit AL op sets Z; following conditions see it
    set_in(1, 4'b1110, 1, 0, 4'b0100);
    tick("t2.set");
    chk("t2.status", 16'(status_q), 16'b0100);
    set_in(1, 4'b0000, 0, 0, 4'd0); #1; chk("t2.eq", 16'(cond_met), 16'd1);
    set_in(1, 4'b0001, 0, 0, 4'd0); #1; chk("t2.ne", 16'(cond_met), 16'd0);
    set_in(1, 4'b1001, 0, 0, 4'd0); #1; chk("t2.ls", 16'(cond_met), 16'd1);
    set_in(1, 4'b1000, 0, 0, 4'd0); #1; chk("t2.hi", 16'(cond_met), 16'd0);
    tick("t2.hi_squash");

    // 3: all 16 conditions against all 16 flag values
    for (int f = 0; f < 16; f++) begin
      set_in(1, 4'b1110, 1, 0, 4'(f));
      tick("t3.set");
      for (int c = 0; c < 16; c++) begin
        set_in(0, 4'(c), 0, 0, 4'd0);
        tick("t3.cond");
      end
    end

    // 4: multi-cycle S-bit op with MC_LATENCY=4
    set_in(1, 4'b1110, 1, 1, 4'b0000); #1;
    chk("t4.stall_T", 16'(stall), 16'd1);
    tick("t4.T");
    #1; chk("t4.stall_T1", 16'(stall), 16'd1);
    tick("t4.T1");
    #1; chk("t4.stall_T2", 16'(stall), 16'd1);
    tick("t4.T2");
    alu_flags = 4'b1000; #1;
    chk("t4.done_T3",  16'(mc_done), 16'd1);
    chk("t4.stall_T3", 16'(stall),   16'd0);
    tick("t4.T3");
    chk("t4.status_T4", 16'(status_q), 16'b1000);

    // 5: freeze for two cycles mid MC_RUN slips completion
    set_in(1, 4'b1110, 1, 1, 4'b0110);
    tick("t5.T");
    tick("t5.T1");
    freeze = 1'b1;
    tick("t5.frz0");
    #1; chk("t5.frz_done", 16'(mc_done), 16'd0);
    tick("t5.frz1");
    freeze = 1'b0;
    chk("t5.frz_status", 16'(status_q), 16'b1000);
    tick("t5.T2");
    alu_flags = 4'b0011; #1;
    chk("t5.done", 16'(mc_done), 16'd1);
    tick("t5.T3");
    chk("t5.status", 16'(status_q), 16'b0011);

    // Reset in the middle of a multi-cycle op: no flag commit
    set_in(1, 4'b1110, 1, 1, 4'b1111);
    tick("rst_mc.T");
    tick("rst_mc.T1");
    do_reset("rst_mc");
    tick("rst_mc.after");

    // 6: trace counters (wrap at CNT_W=4), squash count, reset clears
`ifdef COND_TRACE_EN
    do_reset("t6");
    for (int i = 0; i < 17; i++) begin
      set_in(1, 4'b1110, 0, 0, 4'd0);
      tick("t6.exec");
    end
    chk("t6.exec_wrap", 16'(exec_count), 16'd1);
    set_in(1, 4'b1110, 1, 0, 4'b0100);
    tick("t6.setz");
    set_in(1, 4'b0001, 0, 0, 4'd0);
    tick("t6.ne");
    chk("t6.squash", 16'(squash_count), 16'd1);
    set_in(1, 4'b1110, 1, 1, 4'b1010);
    tick("t6.mc");
    do_reset("t6.mc_rst");
    chk("t6.cnt_clr", 16'(exec_count), 16'd0);
`endif

    // Randomized phase: inputs held stable while the model is busy
    for (int i = 0; i < 600; i++) begin
      if (!m_busy) begin
        set_in($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)));
      end else begin
        alu_flags = 4'($urandom_range(0, 15));
      end
      freeze = ($urandom_range(0, 7) == 0);
      if (m_busy && $urandom_range(0, 29) == 0) do_reset("rnd");
      tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
